// File: rtl/audio_pkg.sv
// Purpose: shared types and default sizes for the clip record/playback engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

   localparam int DEF_NUM_CLIPS = 4;
   localparam int DEF_SAMPLE_W  = 16;
   localparam int DEF_ADDR_W    = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REC,
      ST_PLAY_FETCH,
      ST_PLAY_WAIT,
      ST_PLAY_HOLD
   } engine_state_e;

endpackage

// File: rtl/clip_length_table.sv
// Purpose: per-clip recorded length register file (NUM_CLIPS entries of LEN_W bits).
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none, single write port always accepted.
// Ports: clk/rst (sync, active-high clear), wr_en/wr_clip/wr_len write port,
//        rd_clip/rd_len combinational read port.
module clip_length_table #(
   parameter  int NUM_CLIPS = 4,
   parameter  int LEN_W     = 18,
   localparam int CLIP_W    = $clog2(NUM_CLIPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CLIP_W-1:0] wr_clip,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic [CLIP_W-1:0] rd_clip,
   output logic [LEN_W-1:0]  rd_len
);

   logic [LEN_W-1:0] len_q [NUM_CLIPS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CLIPS; i++) begin
            len_q[i] <= '0;
         end
      end else if (wr_en) begin
         len_q[wr_clip] <= wr_len;
      end
   end

   assign rd_len = len_q[rd_clip];

endmodule

// File: rtl/clip_record_play_engine.sv
// Purpose: records deserializer samples into one flat clip memory and plays a chosen clip back.
// Latency: record write same cycle as the sample strobe; playback >= 3 cycles per sample.
// Backpressure: play_sample_valid_o/data held until play_sample_ready_i; recording has none.
// Optional feature: define LOOP_PLAYBACK_EN to restart a clip at its end instead of stopping.
// Ports: clock_i/reset_i (sync, active-high); play/record command pulses with clip selects;
//        rec_sample_valid_i/rec_sample_i from deserializer; play_sample_* handshake to serializer;
//        mem_* single memory port (rdata 1 cycle after a read); recording_o/playing_o/active_clip_o status.
module clip_record_play_engine
   import audio_pkg::*;
#(
   parameter  int NUM_CLIPS = DEF_NUM_CLIPS,
   parameter  int SAMPLE_W  = DEF_SAMPLE_W,
   parameter  int ADDR_W    = DEF_ADDR_W,
   localparam int CLIP_W    = $clog2(NUM_CLIPS)
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     play_command_i,
   input  logic                     record_command_i,
   input  logic [CLIP_W-1:0]        play_clip_i,
   input  logic [CLIP_W-1:0]        record_clip_i,
   input  logic                     rec_sample_valid_i,
   input  logic [SAMPLE_W-1:0]      rec_sample_i,
   output logic [SAMPLE_W-1:0]      play_sample_o,
   output logic                     play_sample_valid_o,
   input  logic                     play_sample_ready_i,
   output logic                     mem_en_o,
   output logic                     mem_we_o,
   output logic [CLIP_W+ADDR_W-1:0] mem_addr_o,
   output logic [SAMPLE_W-1:0]      mem_wdata_o,
   input  logic [SAMPLE_W-1:0]      mem_rdata_i,
   output logic                     recording_o,
   output logic                     playing_o,
   output logic [CLIP_W-1:0]        active_clip_o
);

   // Lengths need one extra bit so a full clip (DEPTH samples) is representable.
   localparam int               LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   engine_state_e     state;
   logic [CLIP_W-1:0] clip;
   logic [LEN_W-1:0]  idx;

   logic              rec_write;
   logic              play_read;
   logic              rec_full;
   logic              rec_stop;
   logic [LEN_W-1:0]  rec_count_next;
   logic [CLIP_W-1:0] len_rd_clip;
   logic [LEN_W-1:0]  len_rd;
   logic              last_sample;

   // Memory port is driven combinationally so a sample is written in its strobe cycle.
   // Reset suppresses any access in the cycle it is asserted.
   assign rec_write      = !reset_i && (state == ST_REC) && rec_sample_valid_i;
   assign play_read      = !reset_i && (state == ST_PLAY_FETCH);
   assign mem_en_o       = rec_write || play_read;
   assign mem_we_o       = rec_write;
   assign mem_addr_o     = mem_en_o ? {clip, idx[ADDR_W-1:0]} : '0;
   assign mem_wdata_o    = rec_write ? rec_sample_i : '0;

   // A stop pulse coinciding with a sample still counts that sample.
   assign rec_count_next = idx + LEN_W'(rec_sample_valid_i);
   assign rec_full       = rec_sample_valid_i && (idx == DEPTH - LEN_W'(1));
   assign rec_stop       = (state == ST_REC) && (record_command_i || rec_full);

   // In IDLE the table is looked up by the requested clip so an empty clip is refused
   // before playback starts; otherwise by the latched clip for end-of-clip detection.
   assign len_rd_clip    = (state == ST_IDLE) ? play_clip_i : clip;
   assign last_sample    = ((idx + LEN_W'(1)) == len_rd);

   assign active_clip_o  = clip;

   clip_length_table #(
      .NUM_CLIPS (NUM_CLIPS),
      .LEN_W     (LEN_W)
   ) u_len_table (
      .clk     (clock_i),
      .rst     (reset_i),
      .wr_en   (rec_stop),
      .wr_clip (clip),
      .wr_len  (rec_count_next),
      .rd_clip (len_rd_clip),
      .rd_len  (len_rd)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state               <= ST_IDLE;
         clip                <= '0;
         idx                 <= '0;
         play_sample_o       <= '0;
         play_sample_valid_o <= 1'b0;
         recording_o         <= 1'b0;
         playing_o           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (record_command_i) begin
                  clip        <= record_clip_i;
                  idx         <= '0;
                  recording_o <= 1'b1;
                  state       <= ST_REC;
               end else if (play_command_i) begin
                  clip <= play_clip_i;
                  idx  <= '0;
                  if (len_rd != '0) begin
                     playing_o <= 1'b1;
                     state     <= ST_PLAY_FETCH;
                  end
               end
            end

            ST_REC: begin
               if (rec_sample_valid_i) begin
                  idx <= idx + LEN_W'(1);
               end
               if (rec_stop) begin
                  recording_o <= 1'b0;
                  state       <= ST_IDLE;
               end
            end

            ST_PLAY_FETCH: begin
               if (play_command_i) begin
                  playing_o <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_PLAY_WAIT;
               end
            end

            ST_PLAY_WAIT: begin
               if (play_command_i) begin
                  playing_o <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  play_sample_o       <= mem_rdata_i;
                  play_sample_valid_o <= 1'b1;
                  state               <= ST_PLAY_HOLD;
               end
            end

            ST_PLAY_HOLD: begin
               if (play_command_i) begin
                  play_sample_valid_o <= 1'b0;
                  playing_o           <= 1'b0;
                  state               <= ST_IDLE;
               end else if (play_sample_ready_i) begin
                  play_sample_valid_o <= 1'b0;
                  if (last_sample) begin
`ifdef LOOP_PLAYBACK_EN
                     idx   <= '0;
                     state <= ST_PLAY_FETCH;
`else
                     playing_o <= 1'b0;
                     state     <= ST_IDLE;
`endif
                  end else begin
                     idx   <= idx + LEN_W'(1);
                     state <= ST_PLAY_FETCH;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
